block_read_data_mc: RTL and testbench

Parametrised multi-destination RAM read-capture block. A rising edge on i_rd_en starts one RAM read. The returned word is steered into one of NUM_DST destination registers chosen by i_sel, and completion is reported with a done pulse. It sits between the control FSM and the data RAM, and generalises the fixed 3-destination, fixed-latency reader to N destinations with a RAM valid handshake and error reporting.

---
 rtl/block_read_pkg.sv | 20 ++
 rtl/rd_edge_detect.sv | 25 ++
 rtl/block_read_data_mc.sv | 165 ++++++++++++++++
 tb/tb_block_read_data_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/block_read_pkg.sv
// Shared types and helpers for the multi-destination RAM read-capture block.
//   rd_state_t  : read FSM states (IDLE, REQ, WAIT, DONE)
//   sel_width() : selector width needed for n destinations plus the discard code
//   SEL_DISCARD : selector code meaning "read the RAM but keep no copy"
package block_read_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } rd_state_t;

    localparam int unsigned SEL_DISCARD = 0;

    function automatic int unsigned sel_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rd_edge_detect.sv
// Rising-edge pulse generator.
//   i_clk             : clock, rising edge
//   w_rst_sel_data_rd : asynchronous active-low reset (history flop clears to 0)
//   i_level           : level input
//   o_pulse           : high while i_level is 1 and was 0 on the previous edge
module rd_edge_detect (
    input  logic i_clk,
    input  logic w_rst_sel_data_rd,
    input  logic i_level,
    output logic o_pulse
);

    logic level_q;

    always_ff @(posedge i_clk or negedge w_rst_sel_data_rd) begin
        if (!w_rst_sel_data_rd) begin
            level_q <= 1'b0;
        end else begin
            level_q <= i_level;
        end
    end

    assign o_pulse = i_level & ~level_q;

endmodule

// File: rtl/block_read_data_mc.sv
// Multi-destination RAM read-capture block.
// A rising edge on i_rd_en starts one RAM read; the returned word is written into the
// destination register picked by i_sel (0 = discard) and completion is flagged on o_done.
//   i_clk, w_rst_sel_data_rd : clock / asynchronous active-low reset
//   i_rd_en, i_sel           : request level (rising edge starts) and destination select
//   i_ram_data, i_ram_valid  : RAM response, valid is a one-cycle pulse
//   o_ram_rd_en              : one-cycle RAM read strobe per accepted request
//   o_dst_data, o_dst_upd    : destination registers and one-hot write marker
//   o_busy, o_done           : FSM not idle / one-cycle completion
//   o_err, o_drop            : bad selector or timeout / start edge while not idle
// Build option: define READ_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC cycles.
module block_read_data_mc
    import block_read_pkg::*;
#(
    parameter int unsigned SIZE_DATA   = 8,
    parameter int unsigned NUM_DST     = 3,
    parameter int unsigned SEL_W       = sel_width(NUM_DST),
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                         i_clk,
    input  logic                         w_rst_sel_data_rd,
    input  logic                         i_rd_en,
    input  logic [SEL_W-1:0]             i_sel,
    input  logic [SIZE_DATA-1:0]         i_ram_data,
    input  logic                         i_ram_valid,
    output logic                         o_ram_rd_en,
    output logic [NUM_DST*SIZE_DATA-1:0] o_dst_data,
    output logic [NUM_DST-1:0]           o_dst_upd,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err,
    output logic                         o_drop
);

    rd_state_t          state_q;
    logic [SEL_W-1:0]   sel_q;
    logic               ram_rd_en_q;
    logic               done_q;
    logic               err_q;
    logic               drop_q;
    logic [NUM_DST-1:0] dst_upd_q;

    logic               start;
    logic               sel_ok;
    logic               capture;
    logic               expire;
    logic [NUM_DST-1:0] sel_onehot;

    rd_edge_detect u_rd_edge (
        .i_clk             (i_clk),
        .w_rst_sel_data_rd (w_rst_sel_data_rd),
        .i_level           (i_rd_en),
        .o_pulse           (start)
    );

    assign sel_ok = (i_sel <= SEL_W'(NUM_DST));

    // Latched selector k maps to destination k-1; the discard code maps to no bit.
    always_comb begin
        sel_onehot = '0;
        for (int j = 0; j < int'(NUM_DST); j++) begin
            if (sel_q == SEL_W'(j + 1)) begin
                sel_onehot[j] = 1'b1;
            end
        end
    end

    assign capture = (state_q == WAIT) && i_ram_valid && (sel_q != SEL_W'(SEL_DISCARD));

`ifdef READ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Held at zero outside WAIT, so it is already clear on the edge that enters WAIT.
    always_ff @(posedge i_clk or negedge w_rst_sel_data_rd) begin
        if (!w_rst_sel_data_rd) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign expire = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYC));
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign expire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge w_rst_sel_data_rd) begin
        if (!w_rst_sel_data_rd) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ram_rd_en_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            dst_upd_q   <= '0;
        end else begin
            ram_rd_en_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            dst_upd_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (sel_ok) begin
                            sel_q       <= i_sel;
                            ram_rd_en_q <= 1'b1;
                            state_q     <= REQ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                // A valid seen here is too early for the RAM contract and is ignored.
                REQ: state_q <= WAIT;
                WAIT: begin
                    // Valid wins over a timeout expiring on the same edge.
                    if (i_ram_valid) begin
                        done_q    <= 1'b1;
                        dst_upd_q <= sel_onehot;
                        state_q   <= DONE;
                    end else if (expire) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // Requests are only accepted in IDLE; anything else is reported, not queued.
            if (start && (state_q != IDLE)) begin
                drop_q <= 1'b1;
            end
        end
    end

    for (genvar j = 0; j < int'(NUM_DST); j++) begin : g_dst
        logic [SIZE_DATA-1:0] dst_q;

        always_ff @(posedge i_clk or negedge w_rst_sel_data_rd) begin
            if (!w_rst_sel_data_rd) begin
                dst_q <= '0;
            end else if (capture && sel_onehot[j]) begin
                dst_q <= i_ram_data;
            end
        end

        assign o_dst_data[j*SIZE_DATA +: SIZE_DATA] = dst_q;
    end

    assign o_ram_rd_en = ram_rd_en_q;
    assign o_dst_upd   = dst_upd_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_block_read_data_mc.sv
// Bench for block_read_data_mc. Five destinations are used so that selector codes 6 and 7
// exist and the out-of-range path can be exercised with a 3-bit selector.
module tb_block_read_data_mc;

    localparam int unsigned W  = 8;
    localparam int unsigned ND = 5;
    localparam int unsigned SW = $clog2(ND + 1);
    localparam int unsigned TO = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          rd_en     = 1'b0;
    logic [SW-1:0] sel       = '0;
    logic [W-1:0]  ram_data  = '0;
    logic          ram_valid = 1'b0;

    logic          ram_rd_en;
    logic [ND*W-1:0] dst_data;
    logic [ND-1:0] dst_upd;
    logic          busy;
    logic          done;
    logic          err;
    logic          drop;

    int n_checks = 0;
    int n_errors = 0;
    int tnum     = 0;

    // Reference copy of the destination registers.
    logic [W-1:0] mdl [ND];

    always #5 clk = ~clk;

    block_read_data_mc #(
        .SIZE_DATA   (W),
        .NUM_DST     (ND),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .i_clk             (clk),
        .w_rst_sel_data_rd (rst_n),
        .i_rd_en           (rd_en),
        .i_sel             (sel),
        .i_ram_data        (ram_data),
        .i_ram_valid       (ram_valid),
        .o_ram_rd_en       (ram_rd_en),
        .o_dst_data        (dst_data),
        .o_dst_upd         (dst_upd),
        .o_busy            (busy),
        .o_done            (done),
        .o_err             (err),
        .o_drop            (drop)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ND*W-1:0] mdl_vec();
        logic [ND*W-1:0] v;
        for (int j = 0; j < int'(ND); j++) v[j*W +: W] = mdl[j];
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic s, input logic d, input logic e,
                                 input logic dr, input logic b, input logic [ND-1:0] u);
        check_eq($sformatf("%s.strobe", tag), 64'(ram_rd_en), 64'(s));
        check_eq($sformatf("%s.done", tag), 64'(done), 64'(d));
        check_eq($sformatf("%s.err", tag), 64'(err), 64'(e));
        check_eq($sformatf("%s.drop", tag), 64'(drop), 64'(dr));
        check_eq($sformatf("%s.busy", tag), 64'(busy), 64'(b));
        check_eq($sformatf("%s.upd", tag), 64'(dst_upd), 64'(u));
        check_eq($sformatf("%s.dst", tag), 64'(dst_data), 64'(mdl_vec()));
    endtask

    // One read request. s: selector; lat: RAM latency after the strobe (<0: never answers);
    // d: returned word; drop_k: observation at which a second rising edge is driven (0: none,
    // else 2..lat+2); stray: extra valid pulses while in REQ and DONE.
    // Observation k is the cycle following the k-th rising edge after the start edge's
    // predecessor, i.e. k=1 is the cycle right after the start edge.
    task automatic do_read(input int s, input int lat, input logic [W-1:0] d, input int drop_k,
                           input bit stray);
        bit            ok;
        int            k_done;
        logic          e_s, e_d, e_e, e_dr, e_b;
        logic [ND-1:0] e_u;
        string         tag;
        tnum++;
        ok     = (s <= int'(ND));
        k_done = (lat < 0) ? int'(TO) + 3 : lat + 2;
        @(negedge clk);
        rd_en = 1'b1;
        sel   = SW'(s);
        for (int k = 1; k <= k_done + 2; k++) begin
            @(negedge clk);
            e_s  = ok && (k == 1);
            e_d  = ok && (k == k_done);
            e_e  = (!ok && (k == 1)) || (ok && (lat < 0) && (k == k_done));
            e_dr = ok && (drop_k >= 2) && (k == drop_k + 1);
            e_b  = ok && (k <= k_done);
            e_u  = '0;
            if (ok && (lat >= 0) && (k == k_done) && (s != 0)) begin
                e_u[s-1]  = 1'b1;
                mdl[s-1]  = d;
            end
            tag = $sformatf("t%0d.k%0d", tnum, k);
            check_outputs(tag, e_s, e_d, e_e, e_dr, e_b, e_u);
            // Inputs for the next rising edge.
            if (k == 1) begin
                rd_en = 1'b0;
                sel   = SW'($urandom_range(0, 7));
            end
            if (k == drop_k) rd_en = 1'b1;
            if (k == drop_k + 1) rd_en = 1'b0;
            ram_valid = 1'b0;
            ram_data  = W'($urandom);
            if ((lat >= 0) && (k == lat + 1)) begin
                ram_valid = 1'b1;
                ram_data  = d;
            end else if (stray && ((k == 1) || (k == k_done))) begin
                ram_valid = 1'b1;
            end
        end
        @(negedge clk);
        rd_en     = 1'b0;
        ram_valid = 1'b0;
        check_outputs($sformatf("t%0d.tail", tnum), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ram_valid = 1'($urandom_range(0, 1));
            ram_data  = W'($urandom);
            @(negedge clk);
            check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        end
        ram_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        int lat;
        int dk;
        for (int j = 0; j < int'(ND); j++) mdl[j] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Capture into dst1, latency 2: done four cycles after the start edge
        do_read(2, 2, 8'hA5, 0, 1'b0);
        // Discard selector
        do_read(0, 2, 8'h3C, 0, 1'b0);
        // Highest legal selector, then out-of-range selectors
        do_read(int'(ND), 1, 8'h96, 0, 1'b0);
        do_read(int'(ND) + 1, 2, 8'h11, 0, 1'b0);
        do_read(7, 2, 8'h22, 0, 1'b0);
        // Second edge during WAIT, then on the DONE -> IDLE edge
        do_read(1, 3, 8'hC3, 3, 1'b0);
        do_read(3, 2, 8'h4B, 4, 1'b1);

        // Reset in the middle of WAIT; a late RAM response must be ignored
        do_read(2, 2, 8'h5A, 0, 1'b0);
        @(negedge clk);
        rd_en = 1'b1;
        sel   = 3'd2;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check_eq("rst_mid.busy_before", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < int'(ND); j++) mdl[j] = '0;
        check_outputs("rst_mid.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n     = 1'b1;
        ram_valid = 1'b1;
        ram_data  = 8'hFF;
        @(negedge clk);
        ram_valid = 1'b0;
        check_outputs("rst_mid.late", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle_cycles(2);

`ifdef READ_TIMEOUT_EN
        // No response: done and err together; then a response exactly on the expiry edge
        do_read(4, -1, 8'h00, 0, 1'b0);
        do_read(4, int'(TO) + 1, 8'h77, 0, 1'b0);
`endif

        // Randomised traffic
        repeat (150) begin
            s   = int'($urandom_range(0, 7));
            lat = int'($urandom_range(1, 6));
            dk  = 0;
            if ((s <= int'(ND)) && ($urandom_range(0, 2) == 0)) begin
                dk = int'($urandom_range(2, lat + 2));
            end
            do_read(s, lat, W'($urandom), dk, 1'($urandom_range(0, 1)));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
